// File: rtl/debounce_multi.sv
// N-channel input debouncer: 2-FF synchroniser, shared 1 ms prescaler, per-channel debounce counter,
// rise/fall strobes. Define DEBOUNCE_LONGPRESS_EN to generate the per-channel long-press detector.
module debounce_multi #(
    parameter int CHANNELS    = 4,
    parameter int CLKS_PER_MS = 20000,
    parameter int DB_MS       = 10,
    parameter int LONG_MS     = 1000,
    parameter int RESET_VAL   = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] db_in,
    output logic [CHANNELS-1:0] db_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] long_press,
    output logic                ms_tick
);

    localparam int PW = $clog2(CLKS_PER_MS);
    localparam int CW = $clog2(DB_MS + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_MS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_MS - 1);
    localparam logic [CHANNELS-1:0] RST_LVL = {CHANNELS{RESET_VAL != 0}};

    logic [PW-1:0]       pre;
    logic [CHANNELS-1:0] sync_p0;
    logic [CHANNELS-1:0] sync_p1;
    logic [CW-1:0]       cnt [CHANNELS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre <= '0;
        end else if (pre == PRE_LAST) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // The tick marks the cycle in which the prescaler wraps, so it is decoded, not registered.
    assign ms_tick = (pre == PRE_LAST);

    // Stage p0 -> p1: two-flop synchroniser; only sync_p1 feeds the debounce logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= RST_LVL;
            sync_p1 <= RST_LVL;
        end else begin
            sync_p0 <= db_in;
            sync_p1 <= sync_p0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
            db_out <= RST_LVL;
            rise   <= '0;
            fall   <= '0;
        end else begin
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                // Agreement clears the count even on a tick, so any glitch restarts the debounce.
                if (sync_p1[i] == db_out[i]) begin
                    cnt[i] <= '0;
                end else if (ms_tick) begin
                    if (cnt[i] == CNT_LAST) begin
                        cnt[i]    <= '0;
                        db_out[i] <= sync_p1[i];
                        rise[i]   <= sync_p1[i];
                        fall[i]   <= ~sync_p1[i];
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam int LW = $clog2(LONG_MS + 1);
    localparam logic [LW-1:0] LC_MAX  = LW'(LONG_MS);
    localparam logic [LW-1:0] LC_LAST = LW'(LONG_MS - 1);

    logic [LW-1:0] lc [CHANNELS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) lc[i] <= '0;
            long_press <= '0;
        end else begin
            long_press <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                // Saturating at LONG_MS makes the strobe fire once per press.
                if (!db_out[i]) begin
                    lc[i] <= '0;
                end else if (ms_tick && (lc[i] != LC_MAX)) begin
                    lc[i] <= lc[i] + 1'b1;
                    if (lc[i] == LC_LAST) long_press[i] <= 1'b1;
                end
            end
        end
    end
`else
    // An illegal LONG_MS (< 1) shows up as a stuck long_press instead of passing silently.
    assign long_press = {CHANNELS{LONG_MS < 1}};
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi (CHANNELS=4, CLKS_PER_MS=10, DB_MS=4, LONG_MS=8, RESET_VAL=0).
// Long-press expectations follow whether DEBOUNCE_LONGPRESS_EN is defined for the build.
module tb_debounce_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] db_in;
    logic [3:0] db_out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] long_press;
    logic       ms_tick;

    int checks = 0;
    int errors = 0;

    debounce_multi #(
        .CHANNELS   (4),
        .CLKS_PER_MS(10),
        .DB_MS      (4),
        .LONG_MS    (8),
        .RESET_VAL  (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .db_in     (db_in),
        .db_out    (db_out),
        .rise      (rise),
        .fall      (fall),
        .long_press(long_press),
        .ms_tick   (ms_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  n;
        int  m;
        int  ticks;
        bit  found;
        bit  bad;

        reset = 1'b1;
        db_in = 4'b0000;
        repeat (3) step();
        check("reset_db_out", db_out, 4'h0);
        check("reset_strobes", {rise, fall, long_press}, 12'h000);
        check("reset_ms_tick", ms_tick, 1'b0);

        // Step 1: release between edges; edges are then counted from release.
        @(negedge clk);
        reset = 1'b0;
        ticks = 0;
        bad   = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (ms_tick) ticks++;
            if (k == 9 || k == 19 || k == 29) check($sformatf("ms_tick_hi_%0d", k), ms_tick, 1'b1);
            if (k == 8 || k == 10) check($sformatf("ms_tick_lo_%0d", k), ms_tick, 1'b0);
            if (db_out != 4'h0 || rise != 4'h0 || fall != 4'h0 || long_press != 4'h0) bad = 1'b1;
        end
        check("ms_tick_count", ticks, 3);
        check("idle_quiet", bad, 1'b0);

        // Step 2: press channel 0.
        db_in[0] = 1'b1;
        n = 0;
        found = 1'b0;
        while (!found && n < 50) begin
            step();
            n++;
            if (db_out[0]) found = 1'b1;
        end
        check("rise0_seen", found, 1'b1);
        check("rise0_latency_in_range", (n >= 33 && n <= 42), 1'b1);
        check("rise0_strobe", rise, 4'b0001);
        check("rise0_no_fall", fall, 4'b0000);
        check("rise0_others_low", db_out[3:1], 3'b000);
        step();
        check("rise0_one_cycle", rise[0], 1'b0);

        // Step 3: 7-cycle low glitches every 12 cycles must never reach db_out.
        bad = 1'b0;
        for (int r = 0; r < 17; r++) begin
            db_in[0] = 1'b0;
            repeat (7) begin
                step();
                if (!db_out[0] || fall[0]) bad = 1'b1;
            end
            db_in[0] = 1'b1;
            repeat (5) begin
                step();
                if (!db_out[0] || fall[0]) bad = 1'b1;
            end
        end
        check("glitch_filtered", bad, 1'b0);
        check("glitch_db_out0", db_out[0], 1'b1);

        // Step 4: hold channel 1; long press comes 8 ticks (80 cycles) after the rise.
        db_in[1] = 1'b1;
        for (int press = 0; press < 2; press++) begin
            n = 0;
            found = 1'b0;
            while (!found && n < 50) begin
                step();
                n++;
                if (rise[1]) found = 1'b1;
            end
            check($sformatf("rise1_seen_%0d", press), found, 1'b1);
`ifdef DEBOUNCE_LONGPRESS_EN
            m = 0;
            found = 1'b0;
            while (!found && m < 100) begin
                step();
                m++;
                if (long_press[1]) found = 1'b1;
            end
            check($sformatf("long1_seen_%0d", press), found, 1'b1);
            check($sformatf("long1_delay_%0d", press), m, 80);
            check($sformatf("long1_only_ch1_%0d", press), long_press, 4'b0010);
`else
            m = 0;
            repeat (100) begin
                step();
                if (long_press != 4'h0) m++;
            end
            check($sformatf("long_disabled_%0d", press), m, 0);
`endif
            m = 0;
            repeat (500) begin
                step();
                if (long_press[1]) m++;
            end
            check($sformatf("long1_no_repeat_%0d", press), m, 0);
            if (press == 0) begin
                db_in[1] = 1'b0;
                n = 0;
                found = 1'b0;
                while (!found && n < 50) begin
                    step();
                    n++;
                    if (fall[1]) found = 1'b1;
                end
                check("fall1_seen", found, 1'b1);
                db_in[1] = 1'b1;
            end
        end

        // Step 5: simultaneous release of channel 0 and press of channel 3.
        db_in[0] = 1'b0;
        db_in[3] = 1'b1;
        n = 0;
        found = 1'b0;
        while (!found && n < 50) begin
            step();
            n++;
            if (fall[0]) found = 1'b1;
        end
        check("fall0_seen", found, 1'b1);
        check("fall0_rise3_same_edge", {rise, fall}, {4'b1000, 4'b0001});
        check("db_out_after_swap", db_out, 4'b1010);

        // Step 6: reset asynchronously with channel 2 two ticks into its debounce.
        n = 0;
        while (!ms_tick && n < 20) begin
            step();
            n++;
        end
        check("tick_found_before_ch2", ms_tick, 1'b1);
        db_in[2] = 1'b1;
        repeat (21) step();
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_db_out", db_out, 4'h0);
        check("async_reset_strobes", {rise, fall, long_press, 3'b000, ms_tick}, 16'h0000);
        repeat (2) step();
        check("reset_hold_quiet", {db_out, rise, fall}, 12'h000);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        found = 1'b0;
        while (!found && n < 60) begin
            step();
            n++;
            if (rise[2]) found = 1'b1;
        end
        check("rise2_after_reset_seen", found, 1'b1);
        check("rise2_full_latency", (n >= 33 && n <= 42), 1'b1);
        check("rise2_with_others", rise, 4'b1110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
